seg7_time_display: RTL and testbench
====================================

# seg7_time_display

Downstream display stage for the timer: takes the binary `minutes`/`seconds` values produced by the time manager and drives a 4-digit, common-anode, time-multiplexed 7-segment display as MM.SS. It snapshots the time once per scan so the digits never tear, converts each field to two decimal digits, scans the digits with a refresh counter and inserts a blanking gap between digits to suppress ghosting.

## Interface
- `REFRESH_DIV`, 50_000: clock cycles per digit period; ≥ 4.
- `BLANK_CYC`, 16: blanked cycles at the start of each digit period; 1 ≤ BLANK_CYC < REFRESH_DIV.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous and active-high.
- `minutes`  in  6  binary minutes, 0..63 accepted.
- `seconds`  in  6  binary seconds, 0..63 accepted.
- `an`  out  4  digit anodes, active-low; an[0] is the rightmost digit.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation
- State: refresh counter `cnt` (0..REFRESH_DIV-1), digit index `idx` (0..3), snapshot registers `min_s`, `sec_s` (6 b each).
- `cnt` increments every cycle. At REFRESH_DIV-1 it wraps to 0 and `idx` advances 0→1→2→3→0.
- Snapshot: `min_s`/`sec_s` load `minutes`/`seconds` on every cycle where cnt==0 and idx==0, including the first cycle after reset release.
- Digit map: idx0 = sec_s%10, idx1 = sec_s/10, idx2 = min_s%10, idx3 = min_s/10. For inputs up to 63, tens digits are 0..6 with no clamping, so 63 displays as "6","3".
- Segment codes (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Active window: cnt ≥ BLANK_CYC. In the active window, `an` has only bit idx low. In the blank window, an=1111.
- `seg` carries the current digit's code in both windows. Only `an` gates visibility.
- `dp` = 0 only during the idx2 active window, forming the MM.SS separator. Otherwise dp = 1.
- Reset: cnt=0, idx=0, min_s=0, sec_s=0, an=1111, seg=1111111, dp=1.
- Reset asserted mid-scan: outputs take their reset values on the next edge. The scan restarts at idx0 with a fresh snapshot on the first cycle after release.

## Timing
- `an`, `seg` and `dp` are registered. Each output reflects cnt/idx/snapshot from the previous cycle, so output latency is 1 cycle.
- With the snapshot loaded at cycle 0 of a scan, the idx0 code appears on `seg` at cycle 1. The idx0 anode goes low at cycle BLANK_CYC+1.
- A full scan is 4·REFRESH_DIV cycles. Input changes are visible no earlier than the next scan start.
- An input change on the same cycle as the snapshot load is captured. A change one cycle later waits a full scan.

## Configuration
- `LEADING_ZERO_BLANK_EN`:
  - Defined: when min_s/10 == 0, `an` stays 1111 for all of the idx3 period, so the display shows " M.SS".
  - Undefined: idx3 always lights and shows "0" (1000000) for minutes < 10.
- No other behaviour changes.

## Structure
- Shared package `seg7_pkg` holds:
  - the 10-entry active-low segment code constant;
  - the digit-index type (2 b);
  - the blank constants `SEG_OFF` = 7'b1111111 and `AN_OFF` = 4'b1111.
- One sub-module, `seg7_decode`: combinational, 4-bit BCD in → 7-bit active-low code out. Codes 10..15 map to SEG_OFF.

## Test plan
All scenarios use REFRESH_DIV=8 and BLANK_CYC=2.
- Reset: hold rst high 5 cycles -> an=1111, seg=1111111, dp=1 throughout.
- Static value: minutes=12, seconds=34 from reset -> per digit period (an, seg, dp) = (1110, 0011001, 1), (1101, 0110000, 1), (1011, 0100100, 0), (0111, 1111001, 1), with an=1111 for 2 cycles at each period start.
- Mid-scan update: change seconds 34→35 during idx1 -> current scan still shows "4" on idx0; next scan shows 0010010 on idx0.
- Range edge: minutes=63, seconds=63 -> idx0..3 show 3, 6, 3, 6 (0110000, 0000010, 0110000, 0000010).
- Leading zero: minutes=5, seconds=7 -> with LEADING_ZERO_BLANK_EN, an never equals 0111; without it, idx3 shows 1000000.
- Reset mid-scan: assert rst during idx2 active window -> reset outputs next cycle; after release, first output digit is idx0 built from the inputs present at release.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment codes, digit index type and blank constants
package seg7_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Active-low {g,f,e,d,c,b,a} codes for decimal digits 0..9
    localparam logic [6:0] SEG_CODES [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD digit to active-low 7-segment code
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        if (bcd_i <= 4'd9) begin
            seg_o = SEG_CODES[bcd_i];
        end
    end

endmodule

// File: rtl/seg7_time_display.sv
// rtl/seg7_time_display.sv - MM.SS multiplexed 4-digit display driver; optional LEADING_ZERO_BLANK_EN
module seg7_time_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50_000,
    parameter int BLANK_CYC   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    digit_idx_t    idx_q, idx_d;
    logic [5:0]    min_s_q, min_s_d;
    logic [5:0]    sec_s_q, sec_s_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic       snap_load;
    logic [5:0] min_v, sec_v, field;
    logic [3:0] digit;
    logic       active, lit;

    always_comb begin
        snap_load = (cnt_q == '0) && (idx_q == 2'd0);
        // On the load cycle the fresh inputs feed the decoder directly so the
        // first digit of a scan (and after reset) already shows the new value.
        min_v   = snap_load ? minutes : min_s_q;
        sec_v   = snap_load ? seconds : sec_s_q;
        min_s_d = min_v;
        sec_s_d = sec_v;

        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CW'(1);
            idx_d = idx_q;
        end

        field  = idx_q[1] ? min_v : sec_v;
        digit  = idx_q[0] ? 4'(field / 6'd10) : 4'(field % 6'd10);
        active = (cnt_q >= CW'(BLANK_CYC));
        lit    = active;
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_q == 2'd3) && (min_v < 6'd10)) begin
            lit = 1'b0;
        end
`endif
        an_d = lit ? ~(4'b0001 << idx_q) : AN_OFF;
        dp_d = !(active && (idx_q == 2'd2));
    end

    seg7_decode u_decode (
        .bcd_i (digit),
        .seg_o (seg_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            min_s_q <= '0;
            sec_s_q <= '0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            min_s_q <= min_s_d;
            sec_s_q <= sec_s_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_time_display.sv
// tb/tb_seg7_time_display.sv - directed vector bench for seg7_time_display
module tb_seg7_time_display;

    localparam int RD = 8;
    localparam int BC = 2;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_cmp  = 0;
    int n_fail = 0;

    seg7_time_display #(
        .REFRESH_DIV (RD),
        .BLANK_CYC   (BC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .minutes (minutes),
        .seconds (seconds),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]      m;
        logic [5:0]      s;
        logic [3:0][6:0] segs;   // {idx3, idx2, idx1, idx0}
        bit              tens_zero;
    } vec_t;

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0][6:0] exp_segs(input int m, input int s);
        return {ref_seg(m / 10), ref_seg(m % 10), ref_seg(s / 10), ref_seg(s % 10)};
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " an"},  {3'b000, an}, 7'b0001111);
        chk({tag, " seg"}, seg, 7'b1111111);
        chk({tag, " dp"},  {6'd0, dp}, 7'd1);
    endtask

    // Output sampled after edge k reflects cnt=k%RD, idx=(k/RD)%4 of cycle k.
    task automatic check_out(input string tag, input int k, input logic [3:0][6:0] segs, input bit tz);
        int         c;
        int         i;
        logic [3:0] ea;
        logic       ed;
        c = k % RD;
        i = (k / RD) % 4;
        if (c < BC || (i == 3 && LZB && tz)) ea = 4'b1111;
        else ea = ~(4'b0001 << i);
        ed = !(i == 2 && c >= BC);
        chk($sformatf("%s k%0d an", tag, k),  {3'b000, an}, {3'b000, ea});
        chk($sformatf("%s k%0d seg", tag, k), seg, segs[i]);
        chk($sformatf("%s k%0d dp", tag, k),  {6'd0, dp}, {6'd0, ed});
    endtask

    vec_t vecs [5];
    int   sm, ss;

    initial begin
        vecs[0] = '{6'd12, 6'd34, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 1'b0};
        vecs[1] = '{6'd63, 6'd63, {7'b0000010, 7'b0110000, 7'b0000010, 7'b0110000}, 1'b0};
        vecs[2] = '{6'd5,  6'd7,  {7'b1000000, 7'b0010010, 7'b1000000, 7'b1111000}, 1'b1};
        vecs[3] = '{6'd0,  6'd0,  {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 1'b1};
        vecs[4] = '{6'd40, 6'd9,  {7'b0011001, 7'b1000000, 7'b1000000, 7'b0010000}, 1'b0};

        rst     = 1'b1;
        minutes = 6'd0;
        seconds = 6'd0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_reset($sformatf("reset c%0d", i));
        end

        // Static values, run past one scan wrap
        for (int v = 0; v < 5; v++) begin
            rst     = 1'b1;
            minutes = vecs[v].m;
            seconds = vecs[v].s;
            tick();
            rst = 1'b0;
            for (int k = 0; k < 40; k++) begin
                tick();
                check_out($sformatf("vec%0d", v), k, vecs[v].segs, vecs[v].tens_zero);
            end
        end

        // Mid-scan update and snapshot-edge capture
        rst     = 1'b1;
        minutes = 6'd12;
        seconds = 6'd34;
        tick();
        rst = 1'b0;
        sm  = 12;
        ss  = 34;
        for (int k = 0; k < 128; k++) begin
            if (k == 10) seconds = 6'd35;
            if (k == 64) seconds = 6'd36;
            if (k == 65) seconds = 6'd37;
            if (k % (4 * RD) == 0) begin
                sm = int'(minutes);
                ss = int'(seconds);
            end
            tick();
            check_out("upd", k, exp_segs(sm, ss), sm < 10);
            if (k == 1)  chk("upd scan0 idx0", seg, 7'b0011001);
            if (k == 33) chk("upd scan1 idx0", seg, 7'b0010010);
            if (k == 65) chk("upd scan2 idx0", seg, 7'b0000010);
            if (k == 97) chk("upd scan3 idx0", seg, 7'b1111000);
        end

        // Reset asserted in the idx2 active window
        rst     = 1'b1;
        minutes = 6'd12;
        seconds = 6'd34;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 19; k++) begin
            tick();
            check_out("pre", k, exp_segs(12, 34), 1'b0);
        end
        rst = 1'b1;
        tick();
        check_reset("midrst c0");
        minutes = 6'd21;
        seconds = 6'd48;
        tick();
        check_reset("midrst c1");
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            check_out("post", k, exp_segs(21, 48), 1'b0);
            if (k == 0) chk("post first digit", seg, 7'b0000000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
